// File: rtl/usb_tx_pkg.sv
// Shared states, PID constants and defaults for the USB transmit arbiter.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HS   = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } txState_e;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam int IPG_CYC_DEFAULT = 32;

    // A handshake packet is the PID in the low nibble with its check bits above.
    function automatic logic [7:0] hsByte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_ipg_cnt.sv
// Inter-packet gap counter: loads IPG_CYC-1, counts down to zero and holds there.
module usb_tx_ipg_cnt
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYC = IPG_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CNT_W = $clog2(IPG_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(IPG_CYC - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/usb_tx_arb.sv
// Fixed-priority scheduler sharing the phy_tx byte port between handshake and data sources.
// Define USB_TX_IPG_EN to enforce an IPG_CYC-cycle idle gap after every packet.
module usb_tx_arb
    import usb_tx_pkg::*;
#(
    parameter int IPG_CYC = IPG_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_ack,
    input  logic       d_sop,
    input  logic       d_eop,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic [7:0] d_data,
    output logic       d_drop,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [1:0] gnt,
    output logic       busy
);

    txState_e   r_state;
    txState_e   w_nextState;
    logic [3:0] r_pid;
    logic       r_firstBeat;

    logic w_run;
    logic w_hsGrant;
    logic w_dataGrant;
    logic w_dataXfer;
    logic w_pktDone;
    logic w_gapDone;

    assign w_run       = !rst;
    assign w_hsGrant   = (r_state == IDLE) && hs_req;
    assign w_dataGrant = (r_state == IDLE) && !hs_req && d_valid && d_sop;
    assign w_dataXfer  = (r_state == DATA) && d_valid && tx_ready;
    assign w_pktDone   = ((r_state == HS) && tx_ready) || (w_dataXfer && d_eop);

`ifdef USB_TX_IPG_EN
    logic w_cntZero;

    usb_tx_ipg_cnt #(
        .IPG_CYC (IPG_CYC)
    ) u_ipgCnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_pktDone),
        .i_dec  (r_state == GAP),
        .o_zero (w_cntZero)
    );

    assign w_gapDone = (r_state == GAP) && w_cntZero;
    localparam txState_e AfterPkt = GAP;
`else
    logic w_unusedIpg;

    assign w_unusedIpg = (IPG_CYC > 0);
    assign w_gapDone   = 1'b0;
    localparam txState_e AfterPkt = IDLE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // r_firstBeat lets only the opening beat of a data packet carry tx_sop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid       <= '0;
            r_firstBeat <= 1'b0;
        end else begin
            if (w_hsGrant) begin
                r_pid <= hs_pid;
            end
            if (w_dataGrant) begin
                r_firstBeat <= 1'b1;
            end else if (w_dataXfer) begin
                r_firstBeat <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_hsGrant) begin
                    w_nextState = HS;
                end else if (w_dataGrant) begin
                    w_nextState = DATA;
                end
            end
            HS, DATA: begin
                if (w_pktDone) begin
                    w_nextState = AfterPkt;
                end
            end
            GAP: begin
                if (w_gapDone) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Everything is forced low while rst is high, even the pass-through paths.
    always_comb begin
        tx_valid = 1'b0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        tx_data  = '0;
        hs_ack   = 1'b0;
        d_ready  = 1'b0;
        d_drop   = 1'b0;
        gnt      = 2'b00;
        if (w_run) begin
            case (r_state)
                IDLE: begin
                    d_ready = !hs_req && d_valid && !d_sop;
                    d_drop  = !hs_req && d_valid && !d_sop;
                end
                HS: begin
                    tx_valid = 1'b1;
                    tx_sop   = 1'b1;
                    tx_eop   = 1'b1;
                    tx_data  = hsByte(r_pid);
                    hs_ack   = tx_ready;
                    gnt      = 2'b01;
                end
                DATA: begin
                    tx_valid = d_valid;
                    tx_data  = d_data;
                    tx_eop   = d_eop;
                    tx_sop   = d_sop && r_firstBeat;
                    d_ready  = tx_ready;
                    gnt      = 2'b10;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = w_run && (r_state != IDLE);

endmodule

// File: doc/usb_tx_arb.md
Name: usb_tx_arb

Overview:
- Transmit scheduler in front of phy_tx (48 MHz domain).
- Shares the single phy_tx byte-stream port (tx_sop/tx_eop/tx_valid/tx_ready/tx_data) between two requesters: a handshake generator (single-byte PID packets) and a data-packet source (multi-byte stream).
- Fixed priority, no preemption inside a packet. Enforces a minimum inter-packet gap before the next grant.

Parameters:
- IPG_CYC, 32, number of clk cycles idle after a packet's last byte is accepted, before the next grant (must be ≥1).
- CNT_W, $clog2(IPG_CYC+1), localparam: gap counter width; not overridable.

Ports:
- clk  in  1  48 MHz clock.
- rst  in  1  reset, asynchronous, active-high.
- hs_req  in  1  handshake request; held until hs_ack.
- hs_pid  in  4  handshake PID; sampled at grant.
- hs_ack  out  1  one-cycle pulse when the handshake byte is accepted by phy_tx.
- d_sop  in  1  data source: first byte.
- d_eop  in  1  data source: last byte.
- d_valid  in  1  data source byte valid.
- d_ready  out  1  data source back-pressure.
- d_data  in  8  data source byte.
- d_drop  out  1  one-cycle pulse when a stray non-SOP byte is discarded in IDLE.
- tx_sop  out  1  to phy_tx.
- tx_eop  out  1  to phy_tx.
- tx_valid  out  1  to phy_tx.
- tx_ready  in  1  from phy_tx.
- tx_data  out  8  to phy_tx.
- gnt  out  2  one-hot current owner: [0]=handshake, [1]=data; 0 when idle or in gap.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, gap counter=0, latched PID=0. All outputs 0 immediately, including combinational paths. Any packet in flight is abandoned with no EOP.
- Handshake rule: a beat transfers when valid&&ready on that interface. tx_sop/tx_eop/tx_data are meaningful only when tx_valid=1.
- IDLE:
  - If hs_req=1: latch hs_pid, go to HS. This wins over a simultaneous d_valid&&d_sop.
  - Else if d_valid&&d_sop: go to DATA. d_ready stays 0 this cycle, so the SOP byte is held by the source.
  - Else if d_valid&&!d_sop: d_ready=1, byte discarded, d_drop pulses.
  - tx_valid=0.
- HS:
  - tx_valid=1, tx_sop=1, tx_eop=1, tx_data={~pid,pid} (bits [7:4] = bitwise inverse of the latched PID).
  - Request-to-tx_valid latency is 1 cycle.
  - On tx_ready: hs_ack pulses for 1 cycle, go to GAP.
  - hs_req deasserting while in HS does not abort the packet.
- DATA (pass-through, combinational):
  - tx_valid=d_valid, tx_data=d_data, tx_eop=d_eop, d_ready=tx_ready.
  - tx_sop=d_sop only on the first beat of the packet; a d_sop on any later beat is masked to 0.
  - On d_valid&&tx_ready&&d_eop: go to GAP. A single-beat packet (sop and eop together) is legal.
  - hs_req arriving during DATA waits; it is granted after the gap.
- GAP:
  - Counter loads IPG_CYC-1 on entry and decrements each cycle.
  - Go to IDLE in the cycle after the counter reaches 0, giving exactly IPG_CYC cycles in GAP.
  - tx_valid=0, d_ready=0 (no drops occur in GAP).
- A d_valid that is already asserted is never retracted by this block. The source must hold its data until d_ready.

Optional Feature:
- USB_TX_IPG_EN:
  - Defined: GAP state and counter are present, as above.
  - Undefined: GAP, counter and IPG_CYC are unused; the last-byte transfer goes directly to IDLE, and the next grant can occur on the following cycle.

Decomposition:
- Package usb_tx_pkg holds:
  - State enum: IDLE, HS, DATA, GAP.
  - PID constants: PID_ACK=4'b0010, PID_NAK=4'b1010, PID_STALL=4'b1110.
  - Default IPG_CYC.
- One natural sub-module: usb_tx_ipg_cnt (load/decrement/zero flag). It is instantiated only under USB_TX_IPG_EN.

Test Plan:
- hs_req=1, hs_pid=PID_ACK, tx_ready=1 → next cycle tx_valid=1, tx_sop=tx_eop=1, tx_data=8'hD2. hs_ack pulses once, then tx_valid=0 for 32 cycles.
- 4-byte data packet (8'hC3, 8'h01, 8'h02, 8'hE5; sop on the first, eop on the last) with tx_ready toggling 1/0 → bytes appear unchanged and in order, sop only on 8'hC3, d_ready mirrors tx_ready, gnt=2'b10 throughout.
- hs_req and d_valid&&d_sop in the same IDLE cycle → handshake sent first. The data SOP byte is held, then granted 32 cycles after hs_ack.
- Stray d_valid=1, d_sop=0 in IDLE (8'h55) → d_ready=1, d_drop pulses, tx_valid stays 0.
- rst pulsed mid-DATA after 2 of 4 bytes → tx_valid, gnt, busy are 0 immediately. After release, a new packet is granted normally.
- Without USB_TX_IPG_EN: back-to-back handshakes → the second tx_valid is asserted 2 cycles after the first hs_ack.
